// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared types and constants for the ALU control-step sequencer: opcodes,
// control-step states, IR field positions, opcode classes and strobe bundle.
package seq_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00111;
  localparam logic [4:0] OP_ROR = 5'b01000;
  localparam logic [4:0] OP_ROL = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  localparam int OP_MSB = 31;
  localparam int RA_MSB = 26;
  localparam int RB_MSB = 22;
  localparam int RC_MSB = 18;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT
  } state_t;

  typedef enum logic [1:0] {
    CLS_3OP, CLS_2OP, CLS_MULDIV, CLS_ILL
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_low_in;
    logic z_high_in;
    logic z_low_out;
    logic z_high_out;
    logic hi_in;
    logic lo_in;
    logic busy;
    logic done;
    logic illegal;
  } strobes_t;

  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_3OP;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NEG, OP_NOT:                 return CLS_2OP;
      default:                        return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_ir_decode.sv
// Combinational instruction-word decode: opcode class, register indices and
// a flag for register fields that address beyond NUM_REGS.
module seq_ir_decode
  import seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int FW       = 4
) (
  input  logic [31:0]   ir,
  output op_class_t     cls,
  output logic [FW-1:0] ra,
  output logic [FW-1:0] rb,
  output logic [FW-1:0] rc,
  output logic          field_ill
);

  logic ra_bad, rb_bad, rc_bad;
  logic unused_low_bits;

  assign cls = classify(ir[OP_MSB -: 5]);
  assign ra  = ir[RA_MSB -: FW];
  assign rb  = ir[RB_MSB -: FW];
  assign rc  = ir[RC_MSB -: FW];

  assign ra_bad = int'(ra) >= NUM_REGS;
  assign rb_bad = int'(rb) >= NUM_REGS;
  assign rc_bad = int'(rc) >= NUM_REGS;

  // Only the fields an opcode class actually uses can make it illegal.
  always_comb begin
    field_ill = 1'b0;
    case (cls)
      CLS_3OP:             field_ill = ra_bad | rb_bad | rc_bad;
      CLS_MULDIV, CLS_2OP: field_ill = ra_bad | rb_bad;
      default:             field_ill = 1'b0;
    endcase
  end

  assign unused_low_bits = ^ir[RC_MSB-FW:0];

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Moore control-step sequencer (T0..T6) driving DataPath strobes for ALU ops.
// Optional SEQ_PERF_CNT_EN adds instr_count / cycle_count outputs.
module alu_ctrl_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int OPCODE_W    = 5,
  parameter int READ_CYCLES = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [31:0]         ir_word,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_low_in,
  output logic                z_high_in,
  output logic                z_low_out,
  output logic                z_high_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [OPCODE_W-1:0] alu_op,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                busy,
  output logic                done,
  output logic                illegal
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         instr_count,
  output logic [31:0]         cycle_count
`endif
);

  localparam int         FW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] RD_LAST = 4'(READ_CYCLES - 1);

  state_t              state, nx_state;
  logic [3:0]          rd_cnt, nx_rd_cnt;
  logic [31:0]         ir_q, ir_next;
  op_class_t           cls;
  logic [FW-1:0]       ra, rb, rc;
  logic                field_ill, ill;
  strobes_t            stb_q, nx_stb;
  logic [OPCODE_W-1:0] op_q, nx_op;
  logic [NUM_REGS-1:0] rin_q, rout_q, nx_rin, nx_rout;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [FW-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  // Decoding the IR value about to be latched lets T2 branch past T3 for
  // 2-op instructions and lets outputs be registered from the next state.
  assign ir_next = (state == T2) ? ir_word : ir_q;

  seq_ir_decode #(
    .NUM_REGS (NUM_REGS),
    .FW       (FW)
  ) u_decode (
    .ir        (ir_next),
    .cls       (cls),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .field_ill (field_ill)
  );

  assign ill = (cls == CLS_ILL) || field_ill;

  always_comb begin
    nx_state  = state;
    nx_rd_cnt = rd_cnt;
    case (state)
      IDLE:  if (run) nx_state = T0;
      T0: begin
        nx_state  = T1;
        nx_rd_cnt = '0;
      end
      T1: begin
        if (rd_cnt == RD_LAST) begin
          nx_state  = T2;
          nx_rd_cnt = '0;
        end else begin
          nx_rd_cnt = rd_cnt + 4'd1;
        end
      end
      T2:    nx_state = (cls == CLS_2OP && !ill) ? T4 : T3;
      T3:    nx_state = ill ? FAULT : T4;
      T4:    nx_state = T5;
      T5:    nx_state = (cls == CLS_MULDIV) ? T6 : (run ? T0 : IDLE);
      T6:    nx_state = run ? T0 : IDLE;
      FAULT: nx_state = FAULT;
      default: nx_state = IDLE;
    endcase
  end

  always_comb begin
    nx_stb  = '0;
    nx_op   = '0;
    nx_rin  = '0;
    nx_rout = '0;
    case (nx_state)
      T0: begin
        nx_stb.pc_out = 1'b1;
        nx_stb.mar_in = 1'b1;
        nx_stb.inc_pc = 1'b1;
      end
      T1: begin
        nx_stb.read   = 1'b1;
        nx_stb.mdr_in = 1'b1;
      end
      T2: begin
        nx_stb.mdr_out = 1'b1;
        nx_stb.ir_in   = 1'b1;
      end
      T3: begin
        if (!ill) begin
          nx_stb.y_in = 1'b1;
          nx_rout     = onehot((cls == CLS_MULDIV) ? ra : rb);
        end
      end
      T4: begin
        nx_op            = ir_next[OP_MSB -: OPCODE_W];
        nx_stb.z_low_in  = 1'b1;
        nx_stb.z_high_in = (cls == CLS_MULDIV);
        nx_rout          = onehot((cls == CLS_3OP) ? rc : rb);
      end
      T5: begin
        nx_stb.z_low_out = 1'b1;
        if (cls == CLS_MULDIV) begin
          nx_stb.lo_in = 1'b1;
        end else begin
          nx_rin      = onehot(ra);
          nx_stb.done = 1'b1;
        end
      end
      T6: begin
        nx_stb.z_high_out = 1'b1;
        nx_stb.hi_in      = 1'b1;
        nx_stb.done       = 1'b1;
      end
      FAULT:   nx_stb.illegal = 1'b1;
      default: nx_stb = '0;
    endcase
    nx_stb.busy = (nx_state != IDLE) && (nx_state != FAULT);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      rd_cnt <= '0;
      ir_q   <= '0;
      stb_q  <= '0;
      op_q   <= '0;
      rin_q  <= '0;
      rout_q <= '0;
    end else begin
      state  <= nx_state;
      rd_cnt <= nx_rd_cnt;
      ir_q   <= ir_next;
      stb_q  <= nx_stb;
      op_q   <= nx_op;
      rin_q  <= nx_rin;
      rout_q <= nx_rout;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (stb_q.done) instr_count <= instr_count + 32'd1;
      if (stb_q.busy) cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

  assign pc_out     = stb_q.pc_out;
  assign mar_in     = stb_q.mar_in;
  assign inc_pc     = stb_q.inc_pc;
  assign read       = stb_q.read;
  assign mdr_in     = stb_q.mdr_in;
  assign mdr_out    = stb_q.mdr_out;
  assign ir_in      = stb_q.ir_in;
  assign y_in       = stb_q.y_in;
  assign z_low_in   = stb_q.z_low_in;
  assign z_high_in  = stb_q.z_high_in;
  assign z_low_out  = stb_q.z_low_out;
  assign z_high_out = stb_q.z_high_out;
  assign hi_in      = stb_q.hi_in;
  assign lo_in      = stb_q.lo_in;
  assign busy       = stb_q.busy;
  assign done       = stb_q.done;
  assign illegal    = stb_q.illegal;
  assign alu_op     = op_q;
  assign reg_in     = rin_q;
  assign reg_out    = rout_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed bench for alu_ctrl_sequencer: two instances (READ_CYCLES 1 and 3)
// stepped cycle by cycle against hand-computed control-step tables.
module tb_alu_ctrl_sequencer;

  // strobe bit order: pc_out mar_in inc_pc read mdr_in mdr_out ir_in y_in
  //                   z_low_in z_high_in z_low_out z_high_out hi_in lo_in
  typedef struct packed {
    logic [13:0] stb;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        ill;
  } obs_t;

  logic        clock;
  logic        clear;
  logic        run_a, run_b;
  logic [31:0] ir_a, ir_b;
  logic [13:0] stb_a, stb_b;
  logic [15:0] rin_a, rout_a, rin_b, rout_b;
  logic [4:0]  op_a, op_b;
  logic        busy_a, done_a, ill_a, busy_b, done_b, ill_b;

  int checks = 0;
  int errors = 0;

  alu_ctrl_sequencer #(.NUM_REGS(16), .OPCODE_W(5), .READ_CYCLES(1)) dut_a (
    .clock(clock), .clear(clear), .run(run_a), .ir_word(ir_a),
    .pc_out(stb_a[13]), .mar_in(stb_a[12]), .inc_pc(stb_a[11]), .read(stb_a[10]),
    .mdr_in(stb_a[9]), .mdr_out(stb_a[8]), .ir_in(stb_a[7]), .y_in(stb_a[6]),
    .z_low_in(stb_a[5]), .z_high_in(stb_a[4]), .z_low_out(stb_a[3]),
    .z_high_out(stb_a[2]), .hi_in(stb_a[1]), .lo_in(stb_a[0]),
    .alu_op(op_a), .reg_in(rin_a), .reg_out(rout_a),
    .busy(busy_a), .done(done_a), .illegal(ill_a)
  );

  alu_ctrl_sequencer #(.NUM_REGS(16), .OPCODE_W(5), .READ_CYCLES(3)) dut_b (
    .clock(clock), .clear(clear), .run(run_b), .ir_word(ir_b),
    .pc_out(stb_b[13]), .mar_in(stb_b[12]), .inc_pc(stb_b[11]), .read(stb_b[10]),
    .mdr_in(stb_b[9]), .mdr_out(stb_b[8]), .ir_in(stb_b[7]), .y_in(stb_b[6]),
    .z_low_in(stb_b[5]), .z_high_in(stb_b[4]), .z_low_out(stb_b[3]),
    .z_high_out(stb_b[2]), .hi_in(stb_b[1]), .lo_in(stb_b[0]),
    .alu_op(op_b), .reg_in(rin_b), .reg_out(rout_b),
    .busy(busy_b), .done(done_b), .illegal(ill_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic obs_t mk(input logic [13:0] stb, input logic [15:0] rout,
                              input logic [15:0] rin, input logic [4:0] op,
                              input logic busy, input logic done, input logic ill);
    return {stb, rout, rin, op, busy, done, ill};
  endfunction

  function automatic obs_t obs_a();
    return {stb_a, rout_a, rin_a, op_a, busy_a, done_a, ill_a};
  endfunction

  function automatic obs_t obs_b();
    return {stb_b, rout_b, rin_b, op_b, busy_b, done_b, ill_b};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    run_a = 1'b0; run_b = 1'b0;
    ir_a = '0; ir_b = '0;
    repeat (3) step();
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL reset_a got %h want %h", obs_a(), obs_t'('0));
    end
    checks++;
    if (obs_b() !== '0) begin
      errors++;
      $display("FAIL reset_b got %h want %h", obs_b(), obs_t'('0));
    end
    clear = 1'b1;
    repeat (3) step();
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got %h want %h", obs_a(), obs_t'('0));
    end
  endtask

  task automatic test_sub();
    obs_t e[6];
    e[0] = mk(14'h3800, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[1] = mk(14'h0600, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[2] = mk(14'h0180, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[3] = mk(14'h0040, 16'h0008, 16'h0000, 5'h00, 1, 0, 0);
    e[4] = mk(14'h0020, 16'h0080, 16'h0000, 5'h04, 1, 0, 0);
    e[5] = mk(14'h0008, 16'h0000, 16'h0010, 5'h00, 1, 1, 0);
    run_a = 1'b1;
    ir_a  = 32'h221B8000;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (obs_a() !== e[i]) begin
        errors++;
        $display("FAIL sub cyc%0d got %h want %h", i + 1, obs_a(), e[i]);
      end
    end
  endtask

  // NOT issued immediately after SUB's done step; run drops during its T0.
  task automatic test_back_to_back();
    obs_t e[6];
    e[0] = mk(14'h3800, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[1] = mk(14'h0600, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[2] = mk(14'h0180, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[3] = mk(14'h0020, 16'h0040, 16'h0000, 5'h12, 1, 0, 0);
    e[4] = mk(14'h0008, 16'h0000, 16'h0002, 5'h00, 1, 1, 0);
    e[5] = mk(14'h0000, 16'h0000, 16'h0000, 5'h00, 0, 0, 0);
    ir_a = 32'h90B00000;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (obs_a() !== e[i]) begin
        errors++;
        $display("FAIL not_b2b cyc%0d got %h want %h", i + 1, obs_a(), e[i]);
      end
      if (i == 0) run_a = 1'b0;
    end
  endtask

  task automatic test_run_drop();
    obs_t e[7];
    e[0] = mk(14'h3800, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[1] = mk(14'h0600, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[2] = mk(14'h0180, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[3] = mk(14'h0040, 16'h0008, 16'h0000, 5'h00, 1, 0, 0);
    e[4] = mk(14'h0020, 16'h0080, 16'h0000, 5'h04, 1, 0, 0);
    e[5] = mk(14'h0008, 16'h0000, 16'h0010, 5'h00, 1, 1, 0);
    e[6] = mk(14'h0000, 16'h0000, 16'h0000, 5'h00, 0, 0, 0);
    run_a = 1'b1;
    ir_a  = 32'h221B8000;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (obs_a() !== e[i]) begin
        errors++;
        $display("FAIL run_drop cyc%0d got %h want %h", i + 1, obs_a(), e[i]);
      end
      if (i == 4) run_a = 1'b0;
    end
  endtask

  task automatic test_clear_mid();
    obs_t t4;
    t4 = mk(14'h0020, 16'h0080, 16'h0000, 5'h04, 1, 0, 0);
    run_a = 1'b1;
    ir_a  = 32'h221B8000;
    repeat (5) step();
    checks++;
    if (obs_a() !== t4) begin
      errors++;
      $display("FAIL clear_mid_t4 got %h want %h", obs_a(), t4);
    end
    #2;
    clear = 1'b0;
    run_a = 1'b0;
    #1;
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL clear_mid_async got %h want %h", obs_a(), obs_t'('0));
    end
    step();
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL clear_mid_held got %h want %h", obs_a(), obs_t'('0));
    end
    clear = 1'b1;
    step();
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL clear_mid_release got %h want %h", obs_a(), obs_t'('0));
    end
  endtask

  task automatic test_muldiv();
    obs_t e[10];
    e[0] = mk(14'h3800, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[1] = mk(14'h0600, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[2] = mk(14'h0600, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[3] = mk(14'h0600, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[4] = mk(14'h0180, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[5] = mk(14'h0040, 16'h0004, 16'h0000, 5'h00, 1, 0, 0);
    e[6] = mk(14'h0030, 16'h0020, 16'h0000, 5'h0F, 1, 0, 0);
    e[7] = mk(14'h0009, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[8] = mk(14'h0006, 16'h0000, 16'h0000, 5'h00, 1, 1, 0);
    e[9] = mk(14'h0000, 16'h0000, 16'h0000, 5'h00, 0, 0, 0);
    run_b = 1'b1;
    ir_b  = 32'h79280000;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs_b() !== e[i]) begin
        errors++;
        $display("FAIL mul cyc%0d got %h want %h", i + 1, obs_b(), e[i]);
      end
      if (i == 0) run_b = 1'b0;
    end
  endtask

  task automatic test_illegal();
    obs_t e[9];
    e[0] = mk(14'h3800, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[1] = mk(14'h0600, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[2] = mk(14'h0180, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    e[3] = mk(14'h0000, 16'h0000, 16'h0000, 5'h00, 1, 0, 0);
    for (int i = 4; i < 9; i++)
      e[i] = mk(14'h0000, 16'h0000, 16'h0000, 5'h00, 0, 0, 1);
    run_a = 1'b1;
    ir_a  = 32'hF8000000;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (obs_a() !== e[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d got %h want %h", i + 1, obs_a(), e[i]);
      end
    end
    run_a = 1'b0;
    clear = 1'b0;
    #1;
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL illegal_clear got %h want %h", obs_a(), obs_t'('0));
    end
    step();
    clear = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_back_to_back();
    test_run_drop();
    test_clear_mid();
    test_muldiv();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
Hardware control-step sequencer that generates the datapath control strobes for fetch, decode and execute of register-register ALU instructions. It replaces hand-timed stimulus with a parametrised Moore FSM (T0..T6) that runs back-to-back instructions, and adds variable read latency, 2-operand ops, HI/LO write-back for MUL/DIV, and illegal-opcode trapping. It sits beside DataPath; its outputs connect one-to-one to DataPath control inputs.

Parameters:
NUM_REGS, 16, general registers; width of reg_in/reg_out one-hot buses
OPCODE_W, 5, opcode field width (IR[31:27]); drives alu_op width
READ_CYCLES, 1, cycles read/mdr_in are held in T1 (legal range 1..15)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous reset, active-low
run  in  1  level; high = keep fetching instructions
ir_word  in  32  bus value, sampled on the edge that ends T2
pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in  out  1 each  datapath strobes
z_low_in, z_high_in, z_low_out, z_high_out, hi_in, lo_in  out  1 each  Z/HI/LO strobes
alu_op  out  OPCODE_W  opcode to ALU; valid in T4
reg_in  out  NUM_REGS  one-hot register load enable
reg_out  out  NUM_REGS  one-hot register bus drive
busy  out  1  high in any state other than IDLE/FAULT
done  out  1  one-cycle pulse in the last step of each instruction
illegal  out  1  sticky; high in FAULT

Behaviour:
- Reset (clear low, async): state=IDLE, read counter=0, latched IR=0; every output 0.
- All outputs are Moore decodes of registered state plus latched IR fields. In IDLE every output is 0.
- IR fields: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15]. Field width is $clog2(NUM_REGS) from each MSB. A field value >= NUM_REGS is illegal.
- Opcode classes:
  - 3-op: ADD 00011, SUB 00100, SHR 00101, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011.
  - MULDIV: MUL 01111, DIV 10000.
  - 2-op: NEG 10001, NOT 10010.
  - Anything else is illegal.
- IDLE: if run then T0.
- T0: pc_out, mar_in, inc_pc. Next T1.
- T1: read, mdr_in for READ_CYCLES cycles (counter), then T2.
- T2: mdr_out, ir_in; latch ir_word. Next T3.
- T3: decode the latched IR.
  - Illegal: go to FAULT; no strobes in this cycle.
  - 3-op: reg_out[Rb], y_in.
  - MULDIV: reg_out[Ra], y_in.
  - 2-op: skip T3 (go straight from T2 to T4 after decode).
- T4: alu_op=opcode, z_low_in.
  - 3-op: reg_out[Rc].
  - MULDIV: reg_out[Rb], plus z_high_in.
  - 2-op: reg_out[Rb].
- T5:
  - 3-op/2-op: z_low_out, reg_in[Ra], done.
  - MULDIV: z_low_out, lo_in; then T6.
- T6 (MULDIV only): z_high_out, hi_in, done.
- After the done step: if run then T0, else IDLE. Run is sampled only there; dropping run mid-instruction completes the instruction.
- Latency, clocks from T0 entry to done inclusive: 3-op 5+READ_CYCLES; 2-op 4+READ_CYCLES; MULDIV 6+READ_CYCLES.
- alu_op is 0 outside T4. At most one reg_out bit and one reg_in bit are high per cycle.
- FAULT: illegal=1, busy=0, all strobes 0. Held until clear.
- Reset mid-instruction: immediate return to reset state. No further strobes.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds output instr_count[31:0]. It resets to 0 and increments on each done pulse, wrapping 0xFFFFFFFF->0. It also adds cycle_count[31:0], which increments every cycle busy=1.
- Undefined: neither port nor their counters exist. All other behaviour is identical.

Decomposition:
- Package seq_pkg:
  - opcode localparams;
  - state enum (IDLE, T0..T6, FAULT);
  - IR field bit positions;
  - opcode-class enum (CLS_3OP, CLS_2OP, CLS_MULDIV, CLS_ILL).
- Sub-module seq_ir_decode: combinational. Takes the latched IR and NUM_REGS; returns class, Ra/Rb/Rc indices and the field-range-illegal flag.

Test Plan:
- Reset state: hold clear low, pulse clock 3x -> every output 0 and busy=0. Release clear with run=0 -> stays IDLE.
- SUB, READ_CYCLES=1, run=1, ir_word=0x221B8000:
  - T3: reg_out=0x0008, y_in=1.
  - T4: reg_out=0x0080, alu_op=00100, z_low_in=1.
  - T5: z_low_out=1, reg_in=0x0010, done=1.
  - done falls on cycle 6 after T0 entry.
- MUL R2,R5 (0x79280000), READ_CYCLES=3:
  - T1 read held 3 cycles.
  - T4: z_low_in=z_high_in=1.
  - T5: lo_in=1.
  - T6: hi_in=1, done=1.
  - Total 9 cycles.
- NOT R1,R6 (0x90B00000):
  - T3 skipped; T4 reg_out=0x0040.
  - T5 reg_in=0x0002.
  - done at cycle 5.
- Illegal opcode 0xF8000000 -> FAULT: illegal=1, no reg_in ever asserted. Stays until clear, even with run=1.
- Run dropped during T4 of SUB -> instruction completes with done, then IDLE, busy=0. Clear low during T4 -> all outputs 0 immediately.
